// File: rtl/caja_musica_pkg.sv
// Constants shared by the music-box input stage and the `principal` core.
// Debounce timing is derived from the system clock and the debounce window.
package caja_musica_pkg;

    localparam int N_TECLAS         = 7;
    localparam int F_CLK_HZ         = 50_000_000;
    localparam int T_ANTIRREBOTE_MS = 20;

    localparam int CICLOS_ESTABLES  = (F_CLK_HZ / 1000) * T_ANTIRREBOTE_MS;

    // Smallest width that can hold CICLOS_ESTABLES-1; never below one bit.
    function automatic int ancho_para(input int ciclos);
        return (ciclos > 1) ? $clog2(ciclos) : 1;
    endfunction

    localparam int ANCHO_CONT       = ancho_para(CICLOS_ESTABLES);

    typedef enum logic [2:0] {
        NOTA_DO  = 3'd0,
        NOTA_RE  = 3'd1,
        NOTA_MI  = 3'd2,
        NOTA_FA  = 3'd3,
        NOTA_SOL = 3'd4,
        NOTA_LA  = 3'd5,
        NOTA_SI  = 3'd6
    } nota_t;

endpackage

// File: rtl/antirrebote_bit.sv
// Single-key conditioning: two-flop synchroniser, stable-time counter and
// the accepted (debounced) level. Exposes the next level for same-edge use.
module antirrebote_bit #(
    parameter int CICLOS_ESTABLES = caja_musica_pkg::CICLOS_ESTABLES,
    parameter int ANCHO_CONT      = caja_musica_pkg::ANCHO_CONT,
    parameter bit ACTIVO_BAJO     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic cruda,
    output logic estable_sig,
    output logic estable
);
    import caja_musica_pkg::*;

    localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(CICLOS_ESTABLES - 1);

    logic                  sinc_1;
    logic                  sinc_2;
    logic                  s;
    logic [ANCHO_CONT-1:0] cont;
    logic [ANCHO_CONT-1:0] cont_sig;

    // Flops hold the raw-domain idle level so that s reads 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sinc_1 <= ACTIVO_BAJO;
            sinc_2 <= ACTIVO_BAJO;
        end else begin
            sinc_1 <= cruda;
            sinc_2 <= sinc_1;
        end
    end

    assign s = sinc_2 ^ ACTIVO_BAJO;

    always_comb begin
        estable_sig = estable;
        cont_sig    = cont;
        if (s == estable) begin
            cont_sig = '0;
        end else if (cont == LIMITE) begin
            estable_sig = s;
            cont_sig    = '0;
        end else begin
            cont_sig = cont + ANCHO_CONT'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estable <= 1'b0;
            cont    <= '0;
        end else begin
            estable <= estable_sig;
            cont    <= cont_sig;
        end
    end

endmodule

// File: rtl/antirrebote_teclas.sv
// Debounces the raw key lines and narrows them to at most one active key for
// `principal`, with a one-cycle strobe whenever that key bus changes.
module antirrebote_teclas #(
    parameter int N_TECLAS        = caja_musica_pkg::N_TECLAS,
    parameter int CICLOS_ESTABLES = caja_musica_pkg::CICLOS_ESTABLES,
    parameter int ANCHO_CONT      = caja_musica_pkg::ANCHO_CONT,
    parameter bit ACTIVO_BAJO     = 1'b0,
    parameter bit PRIORIDAD       = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_TECLAS-1:0] teclas_crudas,
    output logic [N_TECLAS-1:0] teclas,
    output logic [N_TECLAS-1:0] teclas_estables,
    output logic                cambio
);
    import caja_musica_pkg::*;

    logic [N_TECLAS-1:0] estables_sig;
    logic [N_TECLAS-1:0] teclas_sig;

    for (genvar i = 0; i < N_TECLAS; i++) begin : g_tecla
        antirrebote_bit #(
            .CICLOS_ESTABLES (CICLOS_ESTABLES),
            .ANCHO_CONT      (ANCHO_CONT),
            .ACTIVO_BAJO     (ACTIVO_BAJO)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .cruda       (teclas_crudas[i]),
            .estable_sig (estables_sig[i]),
            .estable     (teclas_estables[i])
        );
    end

    // Filtering the next debounced value keeps teclas/cambio on the same edge
    // as teclas_estables; x & -x isolates the lowest set bit.
    always_comb begin
        teclas_sig = estables_sig;
        if (PRIORIDAD) begin
            teclas_sig = estables_sig & (~estables_sig + N_TECLAS'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            teclas <= '0;
            cambio <= 1'b0;
        end else begin
            teclas <= teclas_sig;
            cambio <= (teclas_sig != teclas);
        end
    end

endmodule

// File: tb/tb_antirrebote_teclas.sv
// Bench for antirrebote_teclas: directed scenarios plus random key activity
// compared each cycle against a sample-history reference model.
module tb_antirrebote_teclas;

    localparam int N = 7;
    localparam int C = 4;
    localparam int W = 3;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] cr_a  = '0;
    logic [N-1:0] cr_b  = '1;
    logic [N-1:0] tec_a, est_a, tec_b, est_b;
    logic         cam_a, cam_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    antirrebote_teclas #(
        .N_TECLAS        (N),
        .CICLOS_ESTABLES (C),
        .ANCHO_CONT      (W),
        .ACTIVO_BAJO     (1'b0),
        .PRIORIDAD       (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .teclas_crudas   (cr_a),
        .teclas          (tec_a),
        .teclas_estables (est_a),
        .cambio          (cam_a)
    );

    antirrebote_teclas #(
        .N_TECLAS        (N),
        .CICLOS_ESTABLES (C),
        .ANCHO_CONT      (W),
        .ACTIVO_BAJO     (1'b1),
        .PRIORIDAD       (1'b1)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .teclas_crudas   (cr_b),
        .teclas          (tec_b),
        .teclas_estables (est_b),
        .cambio          (cam_b)
    );

    task automatic comprobar(input string tag, input logic [N-1:0] obs, input logic [N-1:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, esp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last C synchronised
    // samples all disagree with the accepted level.
    logic [N-1:0] m_p0  [2];
    logic [N-1:0] m_p1  [2];
    logic [N-1:0] m_est [2];
    logic [N-1:0] m_tec [2];
    logic         m_cam [2];
    logic [N-1:0] m_hist[2][C];
    int           m_len [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_p0[d] = '0; m_p1[d] = '0; m_est[d] = '0; m_tec[d] = '0;
                m_cam[d] = 1'b0; m_len[d] = 0;
                for (int k = 0; k < C; k++) m_hist[d][k] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [N-1:0] est_n, tec_n;
                logic         todos, hallado;
                for (int k = C - 1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                m_hist[d][0] = m_p1[d];
                if (m_len[d] < C) m_len[d]++;
                est_n = m_est[d];
                for (int i = 0; i < N; i++) begin
                    todos = (m_len[d] == C);
                    for (int k = 0; k < C; k++)
                        if (m_hist[d][k][i] == m_est[d][i]) todos = 1'b0;
                    if (todos) est_n[i] = ~m_est[d][i];
                end
                tec_n = '0;
                hallado = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!hallado && est_n[i]) begin
                        tec_n[i] = 1'b1;
                        hallado = 1'b1;
                    end
                end
                m_cam[d] = (tec_n != m_tec[d]);
                m_tec[d] = tec_n;
                m_est[d] = est_n;
                m_p1[d]  = m_p0[d];
                m_p0[d]  = (d == 0) ? cr_a : ~cr_b;
            end
        end
    end

    always @(negedge clk) begin
        comprobar("mod_tec_a", tec_a, m_tec[0]);
        comprobar("mod_est_a", est_a, m_est[0]);
        comprobar("mod_cam_a", N'(cam_a), N'(m_cam[0]));
        comprobar("mod_tec_b", tec_b, m_tec[1]);
        comprobar("mod_est_b", est_b, m_est[1]);
        comprobar("mod_cam_b", N'(cam_b), N'(m_cam[1]));
    end

    task automatic flancos(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after a falling edge: asserts reset mid-cycle, checks the
    // outputs cleared before any clock edge, releases on a later falling edge.
    task automatic reset_async();
        #3 reset = 1'b0;
        #1;
        comprobar("rst_tec_a", tec_a, '0);
        comprobar("rst_est_a", est_a, '0);
        comprobar("rst_cam_a", N'(cam_a), '0);
        comprobar("rst_tec_b", tec_b, '0);
        comprobar("rst_est_b", est_b, '0);
        flancos(2);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b0;
        flancos(2);
        reset = 1'b1;
        @(negedge clk);
        comprobar("ini_tec", tec_a, '0);
        comprobar("ini_est", est_a, '0);
        comprobar("ini_cam", N'(cam_a), '0);
        comprobar("ini_tec_b", tec_b, '0);

        // Clean press of key 0: accepted on the sixth edge after first sample.
        cr_a = 7'b0000001;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            comprobar("t1_quieto", {tec_a[N-1:1], cam_a}, '0);
        end
        @(negedge clk);
        comprobar("t1_tec", tec_a, 7'b0000001);
        comprobar("t1_est", est_a, 7'b0000001);
        comprobar("t1_cam", N'(cam_a), N'(1));
        @(negedge clk);
        comprobar("t1_cam_fin", N'(cam_a), '0);

        // Key 2 bounces 1,0,1,0 then holds 1.
        cr_a = '0;
        reset_async();
        cr_a[2] = 1'b1; @(negedge clk); comprobar("t2_rebote", tec_a, '0);
        cr_a[2] = 1'b0; @(negedge clk); comprobar("t2_rebote", tec_a, '0);
        cr_a[2] = 1'b1; @(negedge clk); comprobar("t2_rebote", tec_a, '0);
        cr_a[2] = 1'b0; @(negedge clk); comprobar("t2_rebote", tec_a, '0);
        cr_a[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            comprobar("t2_espera", est_a, '0);
        end
        @(negedge clk);
        comprobar("t2_tec", tec_a, 7'b0000100);
        comprobar("t2_cam", N'(cam_a), N'(1));

        // Keys 1 and 4 together, then release key 1 only.
        cr_a = '0;
        reset_async();
        cr_a = 7'b0010010;
        flancos(5);
        @(negedge clk);
        comprobar("t3_est", est_a, 7'b0010010);
        comprobar("t3_tec", tec_a, 7'b0000010);
        comprobar("t3_cam", N'(cam_a), N'(1));
        @(negedge clk);
        comprobar("t3_cam_fin", N'(cam_a), '0);
        cr_a = 7'b0010000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            comprobar("t3_sin_pulso", N'(cam_a), '0);
        end
        @(negedge clk);
        comprobar("t3_tec_mueve", tec_a, 7'b0010000);
        comprobar("t3_est_mueve", est_a, 7'b0010000);
        comprobar("t3_cam_mueve", N'(cam_a), N'(1));

        // Key 0 held, key 5 added: masked, so no strobe.
        cr_a = '0;
        reset_async();
        cr_a = 7'b0000001;
        flancos(7);
        comprobar("t4_tec0", tec_a, 7'b0000001);
        cr_a = 7'b0100001;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            comprobar("t4_cam", N'(cam_a), '0);
        end
        comprobar("t4_est", est_a, 7'b0100001);
        comprobar("t4_tec", tec_a, 7'b0000001);

        // Reset while key 3 is mid-count, all keys held through reset.
        cr_a = 7'b0101001;
        flancos(4);
        reset_async();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            comprobar("t5_espera", est_a, '0);
        end
        @(negedge clk);
        comprobar("t5_est", est_a, 7'b0101001);
        comprobar("t5_tec", tec_a, 7'b0000001);
        comprobar("t5_cam", N'(cam_a), N'(1));

        // Active-low instance: idle high lines, then key 6 pulled low.
        cr_b = '1;
        reset_async();
        comprobar("t6_reposo", tec_b, '0);
        cr_b = 7'b0111111;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            comprobar("t6_espera", tec_b, '0);
        end
        @(negedge clk);
        comprobar("t6_tec", tec_b, 7'b1000000);
        comprobar("t6_cam", N'(cam_b), N'(1));

        // Random activity alternating bouncy and calm stretches.
        for (int bloque = 0; bloque < 30; bloque++) begin
            int unsigned div;
            div = (bloque % 3 == 0) ? 2 : 10;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, div - 1) == 0) cr_a[i] = ~cr_a[i];
                    if ($urandom_range(0, div - 1) == 0) cr_b[i] = ~cr_b[i];
                end
                if ($urandom_range(0, 299) == 0) reset_async();
            end
        end
        flancos(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
